// File: rtl/dmem_pkg.sv
// Shared types and constants for the MEM-stage data-memory responder.
package dmem_pkg;

   localparam int unsigned DMEM_ADDR_W = 9;
   localparam int unsigned DMEM_DATA_W = 32;
   localparam int unsigned CNT_W       = 4;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } dmem_state_e;

   typedef struct packed {
      logic                   read;
      logic                   write;
      logic [DMEM_ADDR_W-1:0] addr;
      logic [DMEM_DATA_W-1:0] wdata;
      logic [2:0]             func3;
   } dmem_req_t;

endpackage

// File: rtl/dmem_lane_ctl.sv
// Byte-lane steering for RV32 loads/stores: byte enables, store replication,
// load extension and illegal-access detection. Misaligned trapping under DMEM_MISALIGN_TRAP_EN.
module dmem_lane_ctl
   import dmem_pkg::*;
(
   input  logic        read,
   input  logic        write,
   input  logic [2:0]  func3,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] wdata,
   input  logic [31:0] rword,
   output logic [3:0]  be,
   output logic [31:0] wword,
   output logic [31:0] rdata,
   output logic        err
);

   logic [1:0]  lane;
   logic [31:0] shifted;

`ifdef DMEM_MISALIGN_TRAP_EN
   logic misalign;
   assign misalign = (((func3 == F3_H) || (func3 == F3_HU)) && addr_lo[0]) ||
                     ((func3 == F3_W) && (addr_lo != 2'b00));
`endif

   always_comb begin
      be      = 4'b0000;
      wword   = 32'h0;
      rdata   = 32'h0;
      err     = 1'b0;
      lane    = addr_lo;

      // Halfword and word accesses always use the naturally aligned lane
      case (func3)
         F3_H, F3_HU: lane = {addr_lo[1], 1'b0};
         F3_W:        lane = 2'b00;
         default:     lane = addr_lo;
      endcase

      shifted = rword >> {lane, 3'b000};

      if (read && write) begin
         err = 1'b1;
      end else if (read) begin
         case (func3)
            F3_B:    rdata = {{24{shifted[7]}}, shifted[7:0]};
            F3_BU:   rdata = {24'h0, shifted[7:0]};
            F3_H:    rdata = {{16{shifted[15]}}, shifted[15:0]};
            F3_HU:   rdata = {16'h0, shifted[15:0]};
            F3_W:    rdata = rword;
            default: err   = 1'b1;
         endcase
      end else if (write) begin
         case (func3)
            F3_B: begin
               be    = 4'(4'b0001 << lane);
               wword = {4{wdata[7:0]}};
            end
            F3_H: begin
               be    = 4'(4'b0011 << lane);
               wword = {2{wdata[15:0]}};
            end
            F3_W: begin
               be    = 4'b1111;
               wword = wdata;
            end
            default: err = 1'b1;
         endcase
      end

`ifdef DMEM_MISALIGN_TRAP_EN
      if ((read ^ write) && misalign) err = 1'b1;
`endif

      if (err) begin
         be    = 4'b0000;
         wword = 32'h0;
         rdata = 32'h0;
      end
   end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder behind the MEM-stage port: valid/ready request, WAIT_CYC wait states,
// one-cycle response pulse. Optional misaligned-access trap via DMEM_MISALIGN_TRAP_EN.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int unsigned DM_ADDRESS = DMEM_ADDR_W,
   parameter int unsigned DATA_W     = DMEM_DATA_W,
   parameter int unsigned WAIT_CYC   = 2
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_read,
   input  logic                  req_write,
   input  logic [DM_ADDRESS-1:0] req_addr,
   input  logic [DATA_W-1:0]     req_wdata,
   input  logic [2:0]            req_func3,
   output logic                  rsp_valid,
   output logic [DATA_W-1:0]     rsp_rdata,
   output logic                  rsp_err,
   output logic                  busy
);

   localparam int unsigned WORD_W = DM_ADDRESS - 2;
   localparam int unsigned WORDS  = 2 ** WORD_W;

   dmem_state_e      state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   dmem_req_t        req_q, req_nxt, src;

   logic             ready_nxt, busy_nxt, valid_nxt, err_nxt, mem_we;
   logic [31:0]      rdata_nxt;

   logic [3:0]       be;
   logic [31:0]      wword, ld_data, rword;
   logic             lane_err;
   logic [WORD_W-1:0] src_idx;

   logic [31:0]      mem [WORDS];

   assign src_idx = WORD_W'(src.addr >> 2);
   assign rword   = mem[src_idx];

   dmem_lane_ctl u_lane_ctl (
      .read    (src.read),
      .write   (src.write),
      .func3   (src.func3),
      .addr_lo (src.addr[1:0]),
      .wdata   (src.wdata),
      .rword   (rword),
      .be      (be),
      .wword   (wword),
      .rdata   (ld_data),
      .err     (lane_err)
   );

   // Next-state, counter and response decode; src is the incoming request in IDLE
   // so a zero-wait configuration can respond straight from acceptance.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      req_nxt   = req_q;
      src       = req_q;
      mem_we    = 1'b0;
      valid_nxt = 1'b0;
      rdata_nxt = 32'h0;
      err_nxt   = 1'b0;

      case (state)
         IDLE: begin
            src.read  = req_read;
            src.write = req_write;
            src.addr  = DMEM_ADDR_W'(req_addr);
            src.wdata = DMEM_DATA_W'(req_wdata);
            src.func3 = req_func3;
            if (req_valid) begin
               req_nxt   = src;
               cnt_nxt   = CNT_W'(WAIT_CYC);
               state_nxt = (WAIT_CYC == 0) ? RESP : WAIT;
            end
         end
         WAIT: begin
            cnt_nxt = cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) state_nxt = RESP;
         end
         RESP: begin
            mem_we    = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase

      if (state_nxt == RESP) begin
         valid_nxt = 1'b1;
         rdata_nxt = ld_data;
         err_nxt   = lane_err;
      end

      ready_nxt = (state_nxt == IDLE);
      busy_nxt  = (state_nxt != IDLE);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         cnt       <= '0;
         req_q     <= '0;
         req_ready <= 1'b1;
         busy      <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         req_q     <= req_nxt;
         req_ready <= ready_nxt;
         busy      <= busy_nxt;
         rsp_valid <= valid_nxt;
         rsp_rdata <= DATA_W'(rdata_nxt);
         rsp_err   <= err_nxt;
      end
   end

   // Store commits on the edge leaving RESP; reset pulls state out of RESP, dropping it.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         for (int b = 0; b < 4; b++) begin
            if (be[b]) mem[src_idx][8*b +: 8] <= wword[8*b +: 8];
         end
      end
   end

endmodule
